fetch_unit: RTL

Instruction fetch front end for the core. It owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers returned words in a small in-order FIFO. It presents {pc, instruction} pairs to the decode/regfile stage through a valid/ready handshake. Taken branches and jumps are signalled through a redirect port, which flushes buffered and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, imem request/response channels and decode-side output.
// The instr_fault signal exists only when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        instr_fault;
`endif

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    , output instr_fault
`endif
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    , input instr_fault
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem request issue, in-order instruction FIFO, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned redirects into a single faulting nop entry.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [0:0] {StFetch, StFlush} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]     fifo_data_q [FIFO_DEPTH];

  logic            redirect, rsp, pop, push, req_fire, stall;
  logic [31:0]     push_pc, push_data, rsp_pc;
  logic [CntW:0]   occ;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] Nop = 32'h0000_0013;
  logic stall_q, stall_d, fault_pend_q, fault_pend_d, push_fault;
  logic fifo_fault_q [FIFO_DEPTH];
  logic misalign;
  assign misalign = (bus.redirect_pc[1:0] != 2'b00);
  assign stall    = stall_q;
`else
  assign stall    = 1'b0;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(FIFO_DEPTH - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign redirect = bus.redirect_valid;
  assign rsp      = bus.imem_rsp_valid;
  assign pop      = bus.instr_valid && bus.instr_ready;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  // Responses are in order and every in-flight request of this epoch is contiguous, so the
  // oldest outstanding request sits outst_q words behind fetch_pc.
  assign rsp_pc   = fetch_pc_q - (32'(outst_q) << 2);
  // A pop this cycle frees a slot before any newly issued request can return.
  assign occ      = {1'b0, count_q} + {1'b0, outst_q} - {{CntW{1'b0}}, pop};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (drop_d != '0) ? StFlush : StFetch;
    end else begin
      unique case (state_q)
        StFetch: state_d = StFetch;
        StFlush: state_d = (drop_d == '0) ? StFetch : StFlush;
        default: state_d = StFetch;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.imem_req_valid = 1'b0;
    unique case (state_q)
      StFetch: bus.imem_req_valid = !redirect && !stall && (occ < (CntW+1)'(FIFO_DEPTH));
      StFlush: bus.imem_req_valid = 1'b0;
      default: bus.imem_req_valid = 1'b0;
    endcase
  end

  assign bus.imem_req_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    push       = 1'b0;
    push_pc    = rsp_pc;
    push_data  = bus.imem_rsp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    stall_d      = stall_q;
    fault_pend_d = fault_pend_q;
    push_fault   = 1'b0;
`endif
    if (redirect) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      outst_d = '0;
      drop_d  = drop_q + outst_q - CntW'(rsp);
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_pc_d   = bus.redirect_pc;
      stall_d      = misalign;
      fault_pend_d = misalign;
`else
      fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (state_q == StFlush) begin
        if (rsp) drop_d = drop_q - CntW'(1);
      end else if (rsp) begin
        push = 1'b1;
      end
      outst_d = outst_q + CntW'(req_fire) - CntW'(rsp && (state_q == StFetch));
`ifdef FETCH_MISALIGN_CHECK_EN
      // No requests exist while stalled, so this push never collides with a response push.
      if (fault_pend_q) begin
        push         = 1'b1;
        push_pc      = fetch_pc_q;
        push_data    = Nop;
        push_fault   = 1'b1;
        fault_pend_d = 1'b0;
      end
`endif
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[tail_q]   <= push_pc;
      fifo_data_q[tail_q] <= push_data;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q      <= 1'b0;
      fault_pend_q <= 1'b0;
    end else begin
      stall_q      <= stall_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_fault_q[tail_q] <= push_fault;
  end

  assign bus.instr_fault = (count_q != '0) ? fifo_fault_q[head_q] : 1'b0;
`endif

  assign bus.instr_valid = (count_q != '0);
  assign bus.instr_data  = bus.instr_valid ? fifo_data_q[head_q] : 32'h0;
  assign bus.instr_pc    = bus.instr_valid ? fifo_pc_q[head_q] : 32'h0;
endmodule
